// File: rtl/mem_rr_arbiter_if.sv
// Requester and memory-side bundle for mem_rr_arbiter.
// The client/memory side uses the master modport and the arbiter uses the slave modport.
interface mem_rr_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64,
    parameter int LSIZE = $clog2(SIZE),
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_we;
    logic [NREQ-1:0]             req_lock;
    logic [NREQ-1:0][LSIZE-1:0]  req_addr;
    logic [NREQ-1:0][WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_valid;
    logic [WIDTH-1:0]            rsp_rdata;
    logic                        mem_wr_en;
    logic [LSIZE-1:0]            mem_wr_addr;
    logic [WIDTH-1:0]            mem_data_in;
    logic [LSIZE-1:0]            mem_rd_addr;
    logic [WIDTH-1:0]            mem_data_out;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_wr_en, mem_wr_addr, mem_data_in, mem_rd_addr
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_wr_en, mem_wr_addr, mem_data_in, mem_rd_addr
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter giving NREQ requesters one memory access per cycle,
// with bounded lock bursts and a registered 1-cycle read response.
module mem_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int SIZE      = 64,
    parameter int LSIZE     = $clog2(SIZE),
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_rr_arbiter_if.slave  io_bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        if (idx == PW'(NREQ - 1)) begin
            next_idx = {PW{1'b0}};
        end else begin
            next_idx = idx + PW'(1);
        end
    endfunction

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_burst_cnt;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_rdata;

    logic [PW-1:0]     w_winner;
    logic              w_found;
    logic              w_sel_we;
    logic              w_sel_lock;
    logic [LSIZE-1:0]  w_sel_addr;
    logic [WIDTH-1:0]  w_sel_wdata;
    logic              w_burst_more;
    state_t            w_rot_state;
    logic [PW-1:0]     w_rot_ptr;
    logic [CW-1:0]     w_rot_cnt;

    // First valid requester scanning upward from the pointer, modulo NREQ.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = r_ptr;
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && io_bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end else begin
                w_found  = w_found;
            end
            idx = next_idx(idx);
        end
    end

    assign w_sel_we     = w_found & io_bus.req_we[w_winner];
    assign w_sel_lock   = w_found & io_bus.req_lock[w_winner];
    assign w_sel_addr   = io_bus.req_addr[w_winner];
    assign w_sel_wdata  = io_bus.req_wdata[w_winner];
    assign w_burst_more = (int'(r_burst_cnt) + 32'sd1) < MAX_BURST;

    // Grant and memory port drive, combinational in the grant cycle.
    always_comb begin
        io_bus.req_ready   = {NREQ{1'b0}};
        io_bus.mem_wr_en   = 1'b0;
        io_bus.mem_wr_addr = {LSIZE{1'b0}};
        io_bus.mem_data_in = {WIDTH{1'b0}};
        io_bus.mem_rd_addr = {LSIZE{1'b0}};
        if (w_found) begin
            io_bus.req_ready[w_winner] = 1'b1;
            if (w_sel_we) begin
                io_bus.mem_wr_en   = 1'b1;
                io_bus.mem_wr_addr = w_sel_addr;
                io_bus.mem_data_in = w_sel_wdata;
            end else begin
                io_bus.mem_rd_addr = w_sel_addr;
            end
        end else begin
            io_bus.req_ready = {NREQ{1'b0}};
        end
    end

    // Plain rotation outcome; also used when a lock owner goes absent, in which
    // case the cycle behaves as ARB with the pointer already past the owner.
    always_comb begin
        w_rot_state = ST_ARB;
        w_rot_cnt   = {CW{1'b0}};
        w_rot_ptr   = (r_state == ST_LOCKED) ? next_idx(r_ptr) : r_ptr;
        if (w_found) begin
            if (w_sel_lock && (MAX_BURST > 1)) begin
                w_rot_state = ST_LOCKED;
                w_rot_ptr   = w_winner;
                w_rot_cnt   = CW'(1);
            end else begin
                w_rot_ptr   = next_idx(w_winner);
            end
        end else begin
            w_rot_cnt   = {CW{1'b0}};
        end
    end

    // Arbitration FSM: pointer, lock ownership and burst length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ARB;
            r_ptr       <= {PW{1'b0}};
            r_burst_cnt <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_state     <= w_rot_state;
                    r_ptr       <= w_rot_ptr;
                    r_burst_cnt <= w_rot_cnt;
                end
                ST_LOCKED: begin
                    if (io_bus.req_valid[r_ptr]) begin
                        if (w_sel_lock && w_burst_more) begin
                            r_burst_cnt <= r_burst_cnt + CW'(1);
                        end else begin
                            r_state     <= ST_ARB;
                            r_ptr       <= next_idx(r_ptr);
                            r_burst_cnt <= {CW{1'b0}};
                        end
                    end else begin
                        r_state     <= w_rot_state;
                        r_ptr       <= w_rot_ptr;
                        r_burst_cnt <= w_rot_cnt;
                    end
                end
                default: begin
                    r_state     <= ST_ARB;
                    r_ptr       <= {PW{1'b0}};
                    r_burst_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Read response: one-cycle strobe, data held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= {NREQ{1'b0}};
            r_rsp_rdata <= {WIDTH{1'b0}};
        end else if (w_found && !w_sel_we) begin
            r_rsp_valid <= NREQ'(1) << w_winner;
            r_rsp_rdata <= io_bus.mem_data_out;
        end else begin
            r_rsp_valid <= {NREQ{1'b0}};
        end
    end

    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rsp_rdata;
endmodule
